// File: rtl/writeback_stage_reg.sv
// MEM/WB pipeline register with load formatting, writeback source select,
// x0 suppression, misaligned-load detection and a retire counter.
module writeback_stage_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid_in,
    output logic               mem_ready_out,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [XLEN-1:0]    read_data_in,
    input  logic [XLEN-1:0]    pc_plus4_in,
    input  logic [XLEN-1:0]    imm_in,
    input  logic [RADDR_W-1:0] rd_addr_in,
    input  logic               regWrite_in,
    input  logic [1:0]         resultSrc_in,
    input  logic [2:0]         load_funct3_in,
    output logic [XLEN-1:0]    write_data_out,
    output logic [RADDR_W-1:0] rd_addr_out,
    output logic               regWrite_out,
    output logic               wb_valid_out,
    output logic               misalign_out,
    output logic [CNT_W-1:0]   retire_cnt_out
);

    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    logic               valid_q;
    logic [XLEN-1:0]    alu_q;
    logic [XLEN-1:0]    rdata_q;
    logic [XLEN-1:0]    pc4_q;
    logic [XLEN-1:0]    imm_q;
    logic [RADDR_W-1:0] rd_q;
    logic               rw_q;
    logic [1:0]         src_q;
    logic [2:0]         f3_q;
    logic [CNT_W-1:0]   cnt_q;

    // A flushed or empty slot still captures the data fields so the
    // bubble contents are deterministic; only valid_q is cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            src_q   <= SRC_ALU;
            f3_q    <= 3'b000;
        end else if (!stall_in) begin
            valid_q <= mem_valid_in & ~flush_in;
            alu_q   <= alu_result_in;
            rdata_q <= read_data_in;
            pc4_q   <= pc_plus4_in;
            imm_q   <= imm_in;
            rd_q    <= rd_addr_in;
            rw_q    <= regWrite_in;
            src_q   <= resultSrc_in;
            f3_q    <= load_funct3_in;
        end
    end

    // An instruction retires on the edge that moves it out of WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && !stall_in) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_fmt;
    logic             load_mis;

    assign off     = alu_q[OFF_W-1:0];
    assign shifted = rdata_q >> {off, 3'b000};

    always_comb begin
        load_fmt = rdata_q;
        load_mis = 1'b1;
        case (f3_q)
            F3_LB: begin
                load_fmt = XLEN'($signed(shifted[7:0]));
                load_mis = 1'b0;
            end
            F3_LH: begin
                load_fmt = XLEN'($signed(shifted[15:0]));
                load_mis = off[0];
            end
            F3_LW: begin
                load_fmt = XLEN'($signed(shifted[31:0]));
                load_mis = |off[1:0];
            end
            F3_LBU: begin
                load_fmt = XLEN'(shifted[7:0]);
                load_mis = 1'b0;
            end
            F3_LHU: begin
                load_fmt = XLEN'(shifted[15:0]);
                load_mis = off[0];
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    load_fmt = XLEN'(shifted[31:0]);
                    load_mis = |off[1:0];
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    load_fmt = shifted;
                    load_mis = |off;
                end
            end
            default: begin
                load_fmt = rdata_q;
                load_mis = 1'b1;
            end
        endcase
    end

    always_comb begin
        write_data_out = alu_q;
        case (src_q)
            SRC_ALU:  write_data_out = alu_q;
            SRC_LOAD: write_data_out = load_fmt;
            SRC_PC4:  write_data_out = pc4_q;
            SRC_IMM:  write_data_out = imm_q;
            default:  write_data_out = alu_q;
        endcase
    end

    assign misalign_out   = valid_q & (src_q == SRC_LOAD) & rw_q & load_mis;
    assign regWrite_out   = valid_q & rw_q & (rd_q != '0) & ~misalign_out;
    assign wb_valid_out   = valid_q;
    assign rd_addr_out    = rd_q;
    assign retire_cnt_out = cnt_q;
    assign mem_ready_out  = ~stall_in;

endmodule
